// File: rtl/bip_pkg.sv
// Shared definitions for the BIP data-memory responder and its dump engine.
package bip_pkg;

    localparam int LEN_DATA       = 16;
    localparam int LEN_ADDR       = 11;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = LEN_DATA / BYTE_W;

    // Dump engine states, in the order a word passes through them.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND_HI,
        SEND_LO,
        DONE
    } dump_state_e;

    // Big-endian byte select: idx 0 is the most significant byte of the word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [LEN_DATA-1:0] word,
                                                    input int idx);
        return word[(BYTES_PER_WORD - 1 - idx) * BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/bip_ram_sp.sv
// Single-port synchronous RAM, registered read, read-before-write on a shared access.
module bip_ram_sp
    import bip_pkg::*;
#(
    parameter int len_data = LEN_DATA,
    parameter int len_addr = LEN_ADDR
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [len_addr-1:0] addr,
    input  logic [len_data-1:0] wdata,
    output logic [len_data-1:0] rdata
);

    logic [len_data-1:0] mem [2**len_addr];
    logic [len_data-1:0] rdata_q;

    // Storage access: read port captures the old word while a write updates it.
    // NOTE: neither the array nor its read register is reset, so this maps onto a
    // block RAM and the contents survive a reset of the surrounding logic.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bip_data_mem.sv
// BIP data memory: CPU load/store port plus a post-halt dump engine that streams
// words 0..dump_len-1 as big-endian bytes over a valid/ready link to the UART TX.
module bip_data_mem
    import bip_pkg::*;
#(
    parameter int len_data = LEN_DATA,
    parameter int len_addr = LEN_ADDR,
    parameter int dump_len = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Rd,
    input  logic                Wr,
    input  logic [len_addr-1:0] Addr,
    input  logic [len_data-1:0] In_Data,
    output logic [len_data-1:0] Out_Data,
    input  logic                dump_start,
    output logic                dump_busy,
    output logic                dump_done,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    // One extra bit so a full-depth dump reaches its last index without wrapping.
    localparam logic [len_addr:0] LAST_PTR = (len_addr + 1)'(dump_len - 1);

    dump_state_e         state_q, state_d;
    logic [len_addr:0]   ptr_q, ptr_d;
    logic [len_data-1:0] word_q, word_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                dump_busy_q, dump_busy_d;
    logic                dump_done_q, dump_done_d;
    logic                cpu_rd_q, cpu_rd_d;
    logic [len_data-1:0] out_hold_q, out_hold_d;

    logic                cpu_access;
    logic                dump_rd;
    logic                ram_en;
    logic [len_addr-1:0] ram_addr;
    logic [len_data-1:0] ram_rdata;

    bip_ram_sp #(
        .len_data (len_data),
        .len_addr (len_addr)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (Wr),
        .addr  (ram_addr),
        .wdata (In_Data),
        .rdata (ram_rdata)
    );

    // Port arbitration (CPU always wins) and the CPU read-data hold path.
    // NOTE: every signal assigned here gets a value on every path first, so no
    // latch is inferred.
    always_comb begin
        cpu_access = Rd | Wr;
        dump_rd    = (state_q == FETCH) && !cpu_access;
        ram_en     = cpu_access | dump_rd;
        ram_addr   = cpu_access ? Addr : ptr_q[len_addr-1:0];
        cpu_rd_d   = Rd;
        // Once a CPU read result has been presented, freeze it so later dump reads
        // through the shared RAM register never show up on Out_Data.
        out_hold_d = cpu_rd_q ? ram_rdata : out_hold_q;
    end

    // Out_Data is the RAM read register right after a CPU read, the held copy otherwise.
    assign Out_Data = cpu_rd_q ? ram_rdata : out_hold_q;

    // Dump engine next-state, pointer and registered TX outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        word_d      = word_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        dump_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    ptr_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!cpu_access) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // Capture the word so CPU writes during the send cannot corrupt it.
                word_d     = ram_rdata;
                tx_data_d  = word_byte(ram_rdata, 0);
                tx_valid_d = 1'b1;
                state_d    = SEND_HI;
            end
            SEND_HI: begin
                if (tx_ready) begin
                    tx_data_d = word_byte(word_q, 1);
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (ptr_q == LAST_PTR) begin
                        dump_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        dump_busy_d = (state_d != IDLE);
    end

    // All control and output state; asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            word_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            dump_busy_q <= 1'b0;
            dump_done_q <= 1'b0;
            cpu_rd_q    <= 1'b0;
            out_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            dump_busy_q <= dump_busy_d;
            dump_done_q <= dump_done_d;
            cpu_rd_q    <= cpu_rd_d;
            out_hold_q  <= out_hold_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign dump_busy = dump_busy_q;
    assign dump_done = dump_done_q;

endmodule

// File: tb/tb_bip_data_mem.sv
// Self-checking bench for bip_data_mem: CPU port vectors, dump stream, backpressure,
// CPU priority stall and reset in the middle of a dump.
module tb_bip_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        Rd;
    logic        Wr;
    logic [10:0] Addr;
    logic [15:0] In_Data;
    logic [15:0] Out_Data;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_out;
    } cpu_vec_t;

    cpu_vec_t   vecs[12];
    logic [7:0] exp_bytes[8];

    always #5 clk = ~clk;

    bip_data_mem #(
        .len_data (16),
        .len_addr (11),
        .dump_len (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rd         (Rd),
        .Wr         (Wr),
        .Addr       (Addr),
        .In_Data    (In_Data),
        .Out_Data   (Out_Data),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    // Run with tx_ready high until the dump ends; expects bytes from start_idx to the end.
    task automatic drain(input int start_idx);
        int idx      = start_idx;
        int done_cnt = 0;
        bit finished = 1'b0;
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            if (tx_valid) begin
                if (idx < 8) check("tx_byte", {24'h0, tx_data}, {24'h0, exp_bytes[idx]});
                else         check("tx_extra_byte", {31'h0, tx_valid}, 32'h0);
                idx++;
            end
            if (dump_done) done_cnt++;
            if (done_cnt > 0 && !dump_busy) finished = 1'b1;
            else tick();
        end
        check("dump_finished", {31'h0, finished}, 32'h1);
        check("byte_count", idx, 8);
        check("done_pulses", done_cnt, 1);
        check("done_low_in_idle", {31'h0, dump_done}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{rd: 1'b0, wr: 1'b1, addr: 11'd5, wdata: 16'hBEEF, exp_out: 16'h0000};
        vecs[1]  = '{rd: 1'b1, wr: 1'b0, addr: 11'd5, wdata: 16'h0000, exp_out: 16'hBEEF};
        vecs[2]  = '{rd: 1'b0, wr: 1'b0, addr: 11'd5, wdata: 16'h0000, exp_out: 16'hBEEF};
        vecs[3]  = '{rd: 1'b0, wr: 1'b1, addr: 11'd7, wdata: 16'h0001, exp_out: 16'hBEEF};
        vecs[4]  = '{rd: 1'b1, wr: 1'b1, addr: 11'd7, wdata: 16'h1234, exp_out: 16'h0001};
        vecs[5]  = '{rd: 1'b1, wr: 1'b0, addr: 11'd7, wdata: 16'h0000, exp_out: 16'h1234};
        vecs[6]  = '{rd: 1'b0, wr: 1'b1, addr: 11'd0, wdata: 16'h0102, exp_out: 16'h1234};
        vecs[7]  = '{rd: 1'b0, wr: 1'b1, addr: 11'd1, wdata: 16'h0304, exp_out: 16'h1234};
        vecs[8]  = '{rd: 1'b0, wr: 1'b1, addr: 11'd2, wdata: 16'h0506, exp_out: 16'h1234};
        vecs[9]  = '{rd: 1'b0, wr: 1'b1, addr: 11'd3, wdata: 16'h0708, exp_out: 16'h1234};
        vecs[10] = '{rd: 1'b1, wr: 1'b0, addr: 11'd2, wdata: 16'h0000, exp_out: 16'h0506};
        vecs[11] = '{rd: 1'b0, wr: 1'b0, addr: 11'd0, wdata: 16'h0000, exp_out: 16'h0506};
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        reset = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = '0; In_Data = '0;
        dump_start = 1'b0; tx_ready = 1'b0;
        tick();
        tick();
        check("rst_out_data", {16'h0, Out_Data}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_dump_busy", {31'h0, dump_busy}, 32'h0);
        check("rst_dump_done", {31'h0, dump_done}, 32'h0);
        reset = 1'b1;
        tick();

        // CPU port vectors: write, read, hold, read-before-write, dump image load.
        for (int i = 0; i < 12; i++) begin
            Rd = vecs[i].rd; Wr = vecs[i].wr; Addr = vecs[i].addr; In_Data = vecs[i].wdata;
            tick();
            check($sformatf("cpu_vec%0d", i), {16'h0, Out_Data}, {16'h0, vecs[i].exp_out});
        end
        Rd = 1'b0; Wr = 1'b0;

        // Basic dump of four words.
        tx_ready = 1'b1;
        start_dump();
        check("busy_after_start", {31'h0, dump_busy}, 32'h1);
        drain(0);
        check("out_data_untouched_by_dump", {16'h0, Out_Data}, 32'h0506);

        // Backpressure in SEND_HI of word 0, with a CPU write to the word in flight.
        tx_ready = 1'b0;
        start_dump();
        for (int c = 0; c < 20 && !tx_valid; c++) tick();
        check("bp_valid_seen", {31'h0, tx_valid}, 32'h1);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid_stable", {31'h0, tx_valid}, 32'h1);
            check("bp_data_stable", {24'h0, tx_data}, 32'h01);
            Wr = (k == 4); Addr = 11'd0; In_Data = 16'hFFFF;
            tick();
        end
        Wr = 1'b0;
        drain(0);
        Wr = 1'b1; Addr = 11'd0; In_Data = 16'h0102;
        tick();
        Wr = 1'b0;

        // CPU reads hold the engine in FETCH; Out_Data tracks them.
        tx_ready = 1'b1;
        start_dump();
        for (int k = 0; k < 6; k++) begin
            Rd = 1'b1; Addr = 11'(k % 4);
            tick();
            check("stall_out_data", {16'h0, Out_Data},
                  {16'h0, exp_bytes[2 * (k % 4)], exp_bytes[2 * (k % 4) + 1]});
            check("stall_no_valid", {31'h0, tx_valid}, 32'h0);
            check("stall_busy", {31'h0, dump_busy}, 32'h1);
        end
        Rd = 1'b0;
        drain(0);
        check("out_data_after_stall_dump", {16'h0, Out_Data}, 32'h0304);

        // Reset after three accepted bytes, then a fresh dump from word 0.
        begin
            int cnt = 0;
            tx_ready = 1'b1;
            start_dump();
            for (int c = 0; c < 50 && cnt < 3; c++) begin
                if (tx_valid) cnt++;
                tick();
            end
            check("bytes_before_reset", cnt, 3);
        end
        check("valid_before_reset", {31'h0, tx_valid}, 32'h1);
        reset = 1'b0;
        #2;
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_dump_busy", {31'h0, dump_busy}, 32'h0);
        check("mid_rst_out_data", {16'h0, Out_Data}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        Rd = 1'b1; Addr = 11'd3;
        tick();
        Rd = 1'b0;
        check("ram_kept_over_reset", {16'h0, Out_Data}, 32'h0708);
        start_dump();
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bip_data_mem.md
Name: bip_data_mem

Overview:
- Data-memory responder for the BIP processor. It serves the CPU data port: Rd/Wr strobes, the 11-bit data address, and In_Data write data; it returns read data on Out_Data.
- It also contains a dump engine. After the program halts, the engine streams a configurable range of memory out as bytes over a valid/ready handshake to the UART transmitter.
- It sits between the CPU data-memory port and the UART TX, in the top-level BIP wrapper.

Parameters:
- len_data, 16, data word width.
- len_addr, 11, address width; memory depth is 2**len_addr words.
- dump_len, 2048, number of words sent per dump, starting at address 0. Legal range is 1..2**len_addr.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- Rd  input  1  CPU read strobe.
- Wr  input  1  CPU write strobe.
- Addr  input  len_addr  CPU data address.
- In_Data  input  len_data  CPU write data.
- Out_Data  output  len_data  CPU read data, registered.
- dump_start  input  1  single-cycle request to begin a dump.
- dump_busy  output  1  high while the dump FSM is not in IDLE.
- dump_done  output  1  one-cycle pulse after the last byte is accepted.
- tx_data  output  8  byte presented to the UART TX.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART TX accepts the byte.

Behaviour:
- Reset values: Out_Data=0, tx_data=0, tx_valid=0, dump_busy=0, dump_done=0. FSM goes to IDLE and the address counter to 0. RAM contents are not cleared.
- Storage is a single-port synchronous RAM of 2**len_addr x len_data. The CPU port always has priority over the dump engine.
- CPU write: Wr=1 at a rising edge writes In_Data to mem[Addr].
- CPU read: Rd=1 at edge N loads Out_Data with mem[Addr] at edge N (1-cycle latency). Out_Data holds its value when Rd=0.
- Rd and Wr together on the same address: read-before-write. Out_Data gets the old contents and the RAM gets In_Data.
- Dump reads never change Out_Data. Dump data is captured in an internal word_q register.
- Dump FSM states and transitions:
  - IDLE: if dump_start=1, clear ptr and go to FETCH. dump_start in any other state is ignored.
  - FETCH: if Rd=0 and Wr=0, issue a RAM read at ptr and go to LATCH. Otherwise stay in FETCH (stall) and issue nothing.
  - LATCH: word_q <= RAM output; go to SEND_HI.
  - SEND_HI: tx_data=word_q[15:8], tx_valid=1. On tx_valid&tx_ready at an edge, go to SEND_LO.
  - SEND_LO: tx_data=word_q[7:0], tx_valid=1. On handshake: if ptr==dump_len-1, go to DONE; otherwise ptr+1 and go to FETCH.
  - DONE: dump_done=1 for one cycle, then go to IDLE.
- Handshake rules:
  - While tx_valid=1 without tx_ready, tx_data and tx_valid stay stable.
  - tx_valid never drops before the handshake completes.
  - tx_valid=0 in IDLE, FETCH, LATCH and DONE.
  - tx_ready while tx_valid=0 is ignored.
- ptr is len_addr+1 bits wide, so dump_len=2048 terminates correctly without wrap.
- Bytes go out big-endian: high byte of word 0 first.
- CPU writes during SEND_HI or SEND_LO to the address being sent do not alter the byte in flight.
- Reset asserted mid-dump: asynchronous return to the reset values above; tx_valid drops immediately. The next dump_start restarts from address 0.
- Throughput with tx_ready=1 and no CPU access: 4 cycles per word (FETCH, LATCH, SEND_HI, SEND_LO).

Decomposition:
- Shared package bip_pkg holds: constants LEN_DATA=16 and LEN_ADDR=11; the dump-state enum (IDLE, FETCH, LATCH, SEND_HI, SEND_LO, DONE); BYTES_PER_WORD=2.
- One sub-module, bip_ram_sp: a single-port synchronous RAM with registered read and read-before-write, parameterized by len_data and len_addr.
- The CPU/dump arbitration, dump FSM, ptr counter and output registers live in bip_data_mem.

Test Plan:
- CPU write/read: Wr mem[5]=0xBEEF, then Rd Addr=5 → Out_Data=0xBEEF at the Rd edge; Out_Data holds while Rd=0.
- Same-address Rd+Wr: mem[7]=0x0001, then Rd=Wr=1 with Addr=7 and In_Data=0x1234 → Out_Data=0x0001; a following read returns 0x1234.
- Basic dump: dump_len=4, mem[0..3]=0x0102,0x0304,0x0506,0x0708, tx_ready=1 → tx bytes 01 02 03 04 05 06 07 08; exactly one dump_done pulse; dump_busy drops with IDLE.
- Backpressure: hold tx_ready=0 for 10 cycles in SEND_HI of word 0 → tx_valid=1 and tx_data=0x01 stable throughout; the sequence resumes intact when tx_ready=1.
- CPU priority: assert Rd every cycle for 6 cycles while in FETCH → FSM stalls in FETCH and Out_Data follows the CPU reads; the byte stream continues uncorrupted on release.
- Reset mid-dump: drive reset=0 after 3 bytes accepted → tx_valid=0 and dump_busy=0 immediately; RAM contents preserved; a new dump_start sends again from byte 0x01.
